// File: rtl/writeback_ctrl_pkg.sv
// Shared types and constants for the writeback stage: op codes, FSM states,
// register-file write commands and architectural register numbers.
package arm_wb_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_ALU  = 2'b01,
        OP_LOAD = 2'b10,
        OP_BL   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_MEM_REQ  = 2'b01,
        S_MEM_WAIT = 2'b10,
        S_WRITE    = 2'b11
    } state_e;

    localparam logic [1:0] RW_NONE  = 2'b00;
    localparam logic [1:0] RW_LINK  = 2'b10;
    localparam logic [1:0] RW_WRITE = 2'b11;

    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/writeback_ctrl_if.sv
// Writeback stage bus: execute-stage op handshake, data-memory read port and
// register-file write port. Optional forwarding signals exist when WB_FWD_EN is defined.
interface writeback_ctrl_if;
    import arm_wb_pkg::*;

    logic        in_valid;
    logic        in_ready;
    op_e         in_op;
    logic [3:0]  in_rd;
    logic [31:0] in_data;
    logic [31:0] in_pc8;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic [3:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic [1:0]  rf_regwrite;
    logic [31:0] rf_pcplus8;
    logic        busy;

`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [3:0]  fwd_addr;
    logic [31:0] fwd_data;
`endif

    modport slave (
`ifdef WB_FWD_EN
        output fwd_valid, fwd_addr, fwd_data,
`endif
        input  in_valid, in_op, in_rd, in_data, in_pc8,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output in_ready, mem_req, mem_addr,
        output rf_a3, rf_wd3, rf_regwrite, rf_pcplus8, busy
    );

    modport master (
`ifdef WB_FWD_EN
        input  fwd_valid, fwd_addr, fwd_data,
`endif
        output in_valid, in_op, in_rd, in_data, in_pc8,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  in_ready, mem_req, mem_addr,
        input  rf_a3, rf_wd3, rf_regwrite, rf_pcplus8, busy
    );

endinterface

// File: rtl/writeback_ctrl.sv
// Writeback controller: retires ALU/BL ops to the register file and runs
// LOAD ops through the data-memory read port. WB_FWD_EN adds a forwarding port.
//
// state      | meaning
// S_IDLE     | no write this cycle, ready for an op
// S_MEM_REQ  | load request on the bus, waiting for grant
// S_MEM_WAIT | load granted, waiting for read data
// S_WRITE    | register-file write presented this cycle, ready for next op
module writeback_ctrl
    import arm_wb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    writeback_ctrl_if.slave  bus
);

    state_e     state;
    logic [3:0] ld_rd;

    assign bus.in_ready = (state == S_IDLE) || (state == S_WRITE);
    assign bus.busy     = (state == S_MEM_REQ) || (state == S_MEM_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            ld_rd           <= 4'd0;
            bus.rf_regwrite <= RW_NONE;
            bus.rf_a3       <= 4'd0;
            bus.rf_wd3      <= 32'd0;
            bus.rf_pcplus8  <= 32'd0;
            bus.mem_req     <= 1'b0;
            bus.mem_addr    <= 32'd0;
        end else begin
            // write command is a one-cycle pulse; data/address registers hold
            bus.rf_regwrite <= RW_NONE;
            case (state)
                S_IDLE, S_WRITE: begin
                    state <= S_IDLE;
                    if (bus.in_valid) begin
                        case (bus.in_op)
                            OP_ALU: begin
                                state           <= S_WRITE;
                                bus.rf_regwrite <= RW_WRITE;
                                bus.rf_a3       <= bus.in_rd;
                                bus.rf_wd3      <= bus.in_data;
                            end
                            OP_BL: begin
                                state           <= S_WRITE;
                                bus.rf_regwrite <= RW_LINK;
                                bus.rf_pcplus8  <= bus.in_pc8;
                            end
                            OP_LOAD: begin
                                state        <= S_MEM_REQ;
                                ld_rd        <= bus.in_rd;
                                bus.mem_req  <= 1'b1;
                                bus.mem_addr <= word_align(bus.in_data);
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
                S_MEM_REQ: begin
                    if (bus.mem_gnt) begin
                        bus.mem_req <= 1'b0;
                        if (bus.mem_rvalid) begin
                            state           <= S_WRITE;
                            bus.rf_regwrite <= RW_WRITE;
                            bus.rf_a3       <= ld_rd;
                            bus.rf_wd3      <= bus.mem_rdata;
                        end else begin
                            state <= S_MEM_WAIT;
                        end
                    end
                end
                S_MEM_WAIT: begin
                    if (bus.mem_rvalid) begin
                        state           <= S_WRITE;
                        bus.rf_regwrite <= RW_WRITE;
                        bus.rf_a3       <= ld_rd;
                        bus.rf_wd3      <= bus.mem_rdata;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef WB_FWD_EN
    // link writes target R14 with a derived value, so they are not forwarded
    assign bus.fwd_valid = (bus.rf_regwrite == RW_WRITE);
    assign bus.fwd_addr  = bus.rf_a3;
    assign bus.fwd_data  = bus.rf_wd3;
`endif

endmodule

// File: tb/tb_writeback_ctrl.sv
// Self-checking bench for writeback_ctrl: expected register-file writes are
// queued when ops are driven and popped when the DUT issues a write.
module tb_writeback_ctrl;
    import arm_wb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    writeback_ctrl_if bus();

    writeback_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  rw;
        logic [3:0]  a;
        logic [31:0] d;
    } wb_t;

    wb_t         sb[$];
    logic [31:0] rf_model [16];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        wb_t e;
        if (reset !== 1'b1 && bus.rf_regwrite != RW_NONE) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'(bus.rf_regwrite), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_cmd", 32'(bus.rf_regwrite), 32'(e.rw));
                if (e.rw == RW_WRITE) begin
                    chk("wb_a3", 32'(bus.rf_a3), 32'(e.a));
                    chk("wb_wd3", bus.rf_wd3, e.d);
                    rf_model[bus.rf_a3] = bus.rf_wd3;
                end else begin
                    chk("wb_pc8", bus.rf_pcplus8, e.d);
                    rf_model[REG_LR] = bus.rf_pcplus8 - 32'd4;
                end
`ifdef WB_FWD_EN
                chk("fwd_valid", 32'(bus.fwd_valid), (e.rw == RW_WRITE) ? 32'd1 : 32'd0);
                if (e.rw == RW_WRITE) begin
                    chk("fwd_addr", 32'(bus.fwd_addr), 32'(e.a));
                    chk("fwd_data", bus.fwd_data, e.d);
                end
`endif
            end
        end
    end

    task automatic send(input op_e op, input logic [3:0] rd, input logic [31:0] data,
                        input logic [31:0] pc8);
        int w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        if (bus.in_ready !== 1'b1) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_data  = data;
        bus.in_pc8   = pc8;
        if (op == OP_ALU) sb.push_back('{RW_WRITE, rd, data});
        if (op == OP_BL)  sb.push_back('{RW_LINK, 4'd0, pc8});
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] rd, input logic [31:0] addr, input logic [31:0] rdata,
                           input int gnt_dly, input int rv_dly);
        logic [31:0] aligned;
        aligned = {addr[31:2], 2'b00};
        send(OP_LOAD, rd, addr, 32'd0);
        sb.push_back('{RW_WRITE, rd, rdata});
        chk("ld_mem_req", 32'(bus.mem_req), 32'd1);
        chk("ld_mem_addr", bus.mem_addr, aligned);
        chk("ld_busy", 32'(bus.busy), 32'd1);
        repeat (gnt_dly) begin
            tick();
            chk("ld_hold_req", 32'(bus.mem_req), 32'd1);
            chk("ld_hold_addr", bus.mem_addr, aligned);
            chk("ld_req_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.mem_gnt = 1'b1;
        if (rv_dly == 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rdata;
        end
        tick();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        if (rv_dly > 0) begin
            chk("ld_req_drop", 32'(bus.mem_req), 32'd0);
            repeat (rv_dly - 1) begin
                chk("ld_wait_busy", 32'(bus.busy), 32'd1);
                tick();
            end
            chk("ld_wait_ready", 32'(bus.in_ready), 32'd0);
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rdata;
            tick();
            bus.mem_rvalid = 1'b0;
        end
        chk("ld_done_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) rf_model[i] = 32'd0;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_op      = OP_NOP;
        bus.in_rd      = 4'd0;
        bus.in_data    = 32'd0;
        bus.in_pc8     = 32'd0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
        repeat (2) tick();
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_regwrite", 32'(bus.rf_regwrite), 32'd0);
        chk("rst_a3", 32'(bus.rf_a3), 32'd0);
        chk("rst_wd3", bus.rf_wd3, 32'd0);
        chk("rst_pc8", bus.rf_pcplus8, 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        reset = 1'b0;
        tick();

        // ALU write lasts one cycle, then data registers hold
        send(OP_ALU, 4'd3, 32'hDEADBEEF, 32'd0);
        chk("alu_cmd", 32'(bus.rf_regwrite), 32'(RW_WRITE));
        tick();
        chk("alu_one_cycle", 32'(bus.rf_regwrite), 32'(RW_NONE));
        chk("alu_hold_a3", 32'(bus.rf_a3), 32'd3);
        chk("alu_hold_wd3", bus.rf_wd3, 32'hDEADBEEF);

        // BL link write with in_rd ignored
        send(OP_BL, 4'd9, 32'h0, 32'h108);
        chk("bl_cmd", 32'(bus.rf_regwrite), 32'(RW_LINK));
        chk("bl_a3_held", 32'(bus.rf_a3), 32'd3);
        tick();
        chk("bl_one_cycle", 32'(bus.rf_regwrite), 32'(RW_NONE));
        chk("r14_link", rf_model[REG_LR], 32'h104);

        // slow load: grant after 2 cycles, data 3 cycles after grant
        do_load(4'd5, 32'h1003, 32'h55, 2, 3);
        tick();
        chk("r5_load", rf_model[5], 32'h55);

        // load completing on the grant cycle, then ALU back-to-back in WRITE
        do_load(4'd9, 32'h2000, 32'hA5A5A5A5, 0, 0);
        chk("b2b_first", 32'(bus.rf_regwrite), 32'(RW_WRITE));
        send(OP_ALU, REG_PC, 32'h1234, 32'd0);
        chk("b2b_second", 32'(bus.rf_regwrite), 32'(RW_WRITE));
        chk("b2b_rd15", 32'(bus.rf_a3), 32'd15);

        // NOP retires nothing
        send(OP_NOP, 4'd2, 32'h77, 32'd0);
        chk("nop_cmd", 32'(bus.rf_regwrite), 32'(RW_NONE));
        chk("nop_ready", 32'(bus.in_ready), 32'd1);

        // forwarding case ALU rd=7 then BL
        send(OP_ALU, 4'd7, 32'hCAFE0007, 32'd0);
        send(OP_BL, 4'd0, 32'd0, 32'h400);
        tick();

        // reset while waiting for load data, then a stray rvalid
        send(OP_LOAD, 4'd6, 32'h3000, 32'd0);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        chk("rw_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("rw_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rw_rst_busy", 32'(bus.busy), 32'd0);
        chk("rw_rst_req", 32'(bus.mem_req), 32'd0);
        tick();
        reset = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hBAD0BAD0;
        repeat (3) begin
            tick();
            chk("stray_rvalid_cmd", 32'(bus.rf_regwrite), 32'(RW_NONE));
            chk("stray_rvalid_idle", 32'(bus.in_ready), 32'd1);
        end
        bus.mem_rvalid = 1'b0;

        // random mix of ops and memory latencies
        for (int i = 0; i < 24; i++) begin
            int sel;
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: send(OP_ALU, 4'($urandom_range(0, 15)), $urandom, 32'd0);
                1: send(OP_BL, 4'($urandom_range(0, 15)), 32'd0, $urandom);
                2: do_load(4'($urandom_range(0, 15)), $urandom, $urandom,
                           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                default: send(OP_NOP, 4'd0, 32'd0, 32'd0);
            endcase
            if ($urandom_range(0, 3) == 0) tick();
        end

        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
